// File: rtl/piradspi_resp_framer_pkg.sv
// rtl/piradspi_resp_framer_pkg.sv - shared types and constants for the SPI response framer
// Contents:
//   RESP_MAGIC      default response magic (header bits [31:16])
//   resp_hdr_t      {magic[15:0], pad[7:0], id[7:0]}
//   resp_trl_t      {nmagic[15:0], count[15:0]}
//   framer_state_t  IDLE / HEADER / DATA / TRAILER
//   make_hdr()      header word builder
package piradspi_resp_framer_pkg;

    localparam logic [15:0] RESP_MAGIC = 16'hA55A;

    typedef struct packed {
        logic [15:0] magic;
        logic [7:0]  pad;
        logic [7:0]  id;
    } resp_hdr_t;

    typedef struct packed {
        logic [15:0] nmagic;
        logic [15:0] count;
    } resp_trl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_TRAILER
    } framer_state_t;

    function automatic resp_hdr_t make_hdr(input logic [15:0] magic, input logic [7:0] id);
        resp_hdr_t h;
        h.magic = magic;
        h.pad   = 8'h00;
        h.id    = id;
        return h;
    endfunction

endpackage

// File: rtl/piradspi_resp_framer_if.sv
// rtl/piradspi_resp_framer_if.sv - stream bundle between the framer and its environment
// Signals:
//   id_tvalid/id_tready/id_tdata                 command ID stream {empty_flag, id}
//   miso_tvalid/miso_tready/miso_tdata/miso_tlast MISO word stream from the SPI engine
//   resp_tvalid/resp_tready/resp_tdata/resp_tlast framed response stream to the host DMA
//   frame_done                                    pulse after the last frame word handshakes
// Modports:
//   master  framer side (sources the response stream)
//   slave   environment side (sources IDs and MISO words, sinks responses)
interface piradspi_resp_framer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic                  id_tvalid;
    logic                  id_tready;
    logic [ID_WIDTH:0]     id_tdata;

    logic                  miso_tvalid;
    logic                  miso_tready;
    logic [DATA_WIDTH-1:0] miso_tdata;
    logic                  miso_tlast;

    logic                  resp_tvalid;
    logic                  resp_tready;
    logic [DATA_WIDTH-1:0] resp_tdata;
    logic                  resp_tlast;

    logic                  frame_done;

    modport master (
        input  id_tvalid, id_tdata,
        output id_tready,
        input  miso_tvalid, miso_tdata, miso_tlast,
        output miso_tready,
        output resp_tvalid, resp_tdata, resp_tlast,
        input  resp_tready,
        output frame_done
    );

    modport slave (
        output id_tvalid, id_tdata,
        input  id_tready,
        output miso_tvalid, miso_tdata, miso_tlast,
        input  miso_tready,
        input  resp_tvalid, resp_tdata, resp_tlast,
        output resp_tready,
        input  frame_done
    );

endinterface

// File: rtl/piradip_sync_fifo.sv
// rtl/piradip_sync_fifo.sv - single-clock FIFO used as the command ID queue
// Ports:
//   clk, rst          clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data    push; caller only pushes when !full or popping in the same cycle
//   full              DEPTH entries held
//   rd_en, rd_data    pop; rd_data shows the head entry (first-word fall-through)
//   empty             no entries held
module piradip_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Writing the slot being popped is safe: a full FIFO's write slot is the head,
    // and the head is read combinationally before the edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/piradspi_resp_framer.sv
// rtl/piradspi_resp_framer.sv - wraps each SPI command's MISO words into a response frame
// Option macro: PIRADSPI_RESP_TRAILER_EN adds the {~MAGIC, count} trailer word.
// Ports:
//   aclk    clock
//   areset  asynchronous active-high reset
//   bus     piradspi_resp_framer_if.master: ID stream in, MISO stream in,
//           registered response stream out, frame_done pulse out
// Frame: header {MAGIC, 0, id}, the command's MISO words, optional trailer.
module piradspi_resp_framer
    import piradspi_resp_framer_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 8,
    parameter int          ID_DEPTH   = 4,
    parameter logic [15:0] MAGIC      = RESP_MAGIC
) (
    input  logic              aclk,
    input  logic              areset,
    piradspi_resp_framer_if.master bus
);

`ifdef PIRADSPI_RESP_TRAILER_EN
    localparam bit TRAILER_EN = 1'b1;
`else
    localparam bit TRAILER_EN = 1'b0;
`endif

    framer_state_t         state;
    framer_state_t         state_nxt;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ID_WIDTH:0]     fifo_dout;
    logic                  id_tready;

    logic                  cur_empty;

    logic                  resp_tvalid;
    logic [DATA_WIDTH-1:0] resp_tdata;
    logic                  resp_tlast;
    logic                  frame_done;

    logic                  out_free;
    logic                  resp_hs;
    logic                  miso_tready;
    logic                  ld_hdr;
    logic                  ld_data;
    logic [DATA_WIDTH-1:0] hdr_word;

`ifdef PIRADSPI_RESP_TRAILER_EN
    logic                  ld_trl;
    logic                  clr_cnt;
    logic                  trl_loaded;
    logic [15:0]           cnt;
    resp_trl_t             trl;
    logic [DATA_WIDTH-1:0] trl_word;

    assign trl.nmagic = ~MAGIC;
    assign trl.count  = cnt;
    assign trl_word   = DATA_WIDTH'(trl);
`endif

    // The output register can take a new word when empty or when its word leaves now.
    assign out_free = !resp_tvalid || bus.resp_tready;
    assign resp_hs  = resp_tvalid && bus.resp_tready;
    assign hdr_word = DATA_WIDTH'(make_hdr(MAGIC, 8'(fifo_dout[ID_WIDTH-1:0])));

    // A pop in the same cycle frees a slot, so a full queue still accepts a push.
    assign id_tready = !fifo_full || fifo_pop;
    assign fifo_push = bus.id_tvalid && id_tready;

    assign bus.id_tready   = id_tready;
    assign bus.miso_tready = miso_tready;
    assign bus.resp_tvalid = resp_tvalid;
    assign bus.resp_tdata  = resp_tdata;
    assign bus.resp_tlast  = resp_tlast;
    assign bus.frame_done  = frame_done;

    piradip_sync_fifo #(
        .WIDTH (ID_WIDTH + 1),
        .DEPTH (ID_DEPTH)
    ) u_id_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (fifo_push),
        .wr_data (bus.id_tdata),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_dout),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt   = state;
        fifo_pop    = 1'b0;
        miso_tready = 1'b0;
        ld_hdr      = 1'b0;
        ld_data     = 1'b0;
`ifdef PIRADSPI_RESP_TRAILER_EN
        ld_trl      = 1'b0;
        clr_cnt     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && out_free) begin
                    fifo_pop  = 1'b1;
                    ld_hdr    = 1'b1;
                    state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (resp_hs) begin
                    if (!cur_empty) begin
                        state_nxt = ST_DATA;
                    end else begin
`ifdef PIRADSPI_RESP_TRAILER_EN
                        ld_trl    = 1'b1;
                        state_nxt = ST_TRAILER;
`else
                        state_nxt = ST_IDLE;
`endif
                    end
                end
            end
            ST_DATA: begin
                miso_tready = out_free;
                if (bus.miso_tvalid && out_free) begin
                    ld_data = 1'b1;
                    if (bus.miso_tlast) begin
`ifdef PIRADSPI_RESP_TRAILER_EN
                        state_nxt = ST_TRAILER;
`else
                        state_nxt = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PIRADSPI_RESP_TRAILER_EN
            // Entered from DATA with the last data word possibly still in the output
            // register; the trailer is loaded once that word has gone.
            ST_TRAILER: begin
                if (trl_loaded) begin
                    if (resp_hs) begin
                        clr_cnt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (out_free) begin
                    ld_trl = 1'b1;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            cur_empty <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_pop) cur_empty <= fifo_dout[ID_WIDTH];
        end
    end

`ifdef PIRADSPI_RESP_TRAILER_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt        <= '0;
            trl_loaded <= 1'b0;
        end else begin
            if (clr_cnt) begin
                cnt <= '0;
            end else if (ld_data && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            if (clr_cnt) begin
                trl_loaded <= 1'b0;
            end else if (ld_trl) begin
                trl_loaded <= 1'b1;
            end
        end
    end
`endif

    // Loads only happen when out_free, so a stalled word is never overwritten.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            resp_tvalid <= 1'b0;
            resp_tdata  <= '0;
            resp_tlast  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= resp_hs && resp_tlast;
            if (ld_hdr) begin
                resp_tvalid <= 1'b1;
                resp_tdata  <= hdr_word;
                resp_tlast  <= !TRAILER_EN && fifo_dout[ID_WIDTH];
            end else if (ld_data) begin
                resp_tvalid <= 1'b1;
                resp_tdata  <= bus.miso_tdata;
                resp_tlast  <= !TRAILER_EN && bus.miso_tlast;
`ifdef PIRADSPI_RESP_TRAILER_EN
            end else if (ld_trl) begin
                resp_tvalid <= 1'b1;
                resp_tdata  <= trl_word;
                resp_tlast  <= 1'b1;
`endif
            end else if (resp_hs) begin
                resp_tvalid <= 1'b0;
                resp_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piradspi_resp_framer.sv
// tb/tb_piradspi_resp_framer.sv - self-checking bench for piradspi_resp_framer
module tb_piradspi_resp_framer;

`ifdef PIRADSPI_RESP_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0]  id;
        logic        empty;
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        logic [31:0] exp_hdr;
        logic [31:0] exp_trl;
    } frame_vec_t;

    logic aclk;
    logic areset;
    int   rdy_mode;
    int   n_checks;
    int   n_fail;
    int   frames_exp;
    int   frames_seen;
    bit   aborted;
    exp_t exp_q[$];

    logic        stall_prev;
    logic        hs_last_prev;
    logic [31:0] prev_data;
    logic        prev_last;

    frame_vec_t vecs[5];

    piradspi_resp_framer_if #(.DATA_WIDTH(32), .ID_WIDTH(8)) bus ();

    piradspi_resp_framer #(
        .DATA_WIDTH (32),
        .ID_WIDTH   (8),
        .ID_DEPTH   (4),
        .MAGIC      (16'hA55A)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        n_checks++;
        n_fail++;
        aborted = 1'b1;
        $display("FAIL %s: timed out waiting, expected handshake", name);
    endfunction

    function automatic void expect_frame(input logic [31:0] hdr, input logic empty, input int n,
                                         input logic [31:0] base, input logic [31:0] step,
                                         input logic [31:0] trl);
        exp_t e;
        e.data = hdr;
        e.last = !TRL && empty;
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.data = base + step * 32'(i);
            e.last = !TRL && (i == n - 1);
            exp_q.push_back(e);
        end
        if (TRL) begin
            e.data = trl;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
        frames_exp++;
    endfunction

    // All stimulus tasks start and end at posedge+1.
    task automatic push_id(input logic empty, input logic [7:0] id);
        int t = 0;
        if (aborted) return;
        bus.id_tvalid = 1'b1;
        bus.id_tdata  = {empty, id};
        forever begin
            @(negedge aclk);
            if (bus.id_tready) break;
            t++;
            if (t > 3000) begin
                timeout("id_accept");
                break;
            end
        end
        @(posedge aclk);
        #1;
        bus.id_tvalid = 1'b0;
    endtask

    task automatic send_miso(input logic [31:0] d, input logic l);
        int t = 0;
        if (aborted) return;
        bus.miso_tvalid = 1'b1;
        bus.miso_tdata  = d;
        bus.miso_tlast  = l;
        forever begin
            @(negedge aclk);
            if (bus.miso_tready) break;
            t++;
            if (t > 3000) begin
                timeout("miso_accept");
                break;
            end
        end
        @(posedge aclk);
        #1;
        bus.miso_tvalid = 1'b0;
        bus.miso_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic empty, input int n,
                              input logic [31:0] base, input logic [31:0] step,
                              input logic [31:0] hdr, input logic [31:0] trl, input bit gaps);
        expect_frame(hdr, empty, n, base, step, trl);
        push_id(empty, id);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            send_miso(base + step * 32'(i), i == n - 1);
        end
    endtask

    task automatic wait_drain(input int limit);
        int t = 0;
        if (aborted) return;
        while (exp_q.size() != 0) begin
            @(negedge aclk);
            t++;
            if (t > limit) begin
                timeout("resp_drain");
                break;
            end
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        bus.resp_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       bus.resp_tready = 1'b1;
                1:       bus.resp_tready = ($urandom_range(0, 99) >= 30);
                default: bus.resp_tready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard pop, hold-under-stall and frame_done checks.
    initial begin
        exp_t e;
        stall_prev   = 1'b0;
        hs_last_prev = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall_prev   = 1'b0;
                hs_last_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", bus.resp_tvalid, 1'b1);
                    check("hold_data", bus.resp_tdata, prev_data);
                    check("hold_last", bus.resp_tlast, prev_last);
                end
                if (hs_last_prev || bus.frame_done)
                    check("frame_done", bus.frame_done, hs_last_prev);
                if (bus.frame_done) frames_seen++;
                hs_last_prev = 1'b0;
                if (bus.resp_tvalid && bus.resp_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL resp_extra: got word %0h, expected no word", bus.resp_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_tdata", bus.resp_tdata, e.data);
                        check("resp_tlast", bus.resp_tlast, e.last);
                    end
                    hs_last_prev = bus.resp_tlast;
                end
                stall_prev = bus.resp_tvalid && !bus.resp_tready;
                prev_data  = bus.resp_tdata;
                prev_last  = bus.resp_tlast;
            end
        end
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        frames_exp      = 0;
        frames_seen     = 0;
        aborted         = 1'b0;
        rdy_mode        = 0;
        areset          = 1'b1;
        bus.id_tvalid   = 1'b0;
        bus.id_tdata    = '0;
        bus.miso_tvalid = 1'b0;
        bus.miso_tdata  = '0;
        bus.miso_tlast  = 1'b0;

        vecs[0] = '{8'h03, 1'b0, 3, 32'h11,       32'h11, 32'hA55A0003, 32'h5AA50003};
        vecs[1] = '{8'h07, 1'b1, 0, 32'h0,        32'h0,  32'hA55A0007, 32'h5AA50000};
        vecs[2] = '{8'hFF, 1'b0, 1, 32'hDEADBEEF, 32'h0,  32'hA55A00FF, 32'h5AA50001};
        vecs[3] = '{8'h00, 1'b0, 5, 32'h1,        32'h1,  32'hA55A0000, 32'h5AA50005};
        vecs[4] = '{8'h5A, 1'b1, 0, 32'h0,        32'h0,  32'hA55A005A, 32'h5AA50000};

        repeat (3) @(posedge aclk);
        #1;
        check("rst_resp_tvalid", bus.resp_tvalid, 1'b0);
        check("rst_resp_tdata", bus.resp_tdata, 32'h0);
        check("rst_resp_tlast", bus.resp_tlast, 1'b0);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_miso_tready", bus.miso_tready, 1'b0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Directed frames from the table, full-rate downstream.
        foreach (vecs[i]) begin
            send_frame(vecs[i].id, vecs[i].empty, vecs[i].n, vecs[i].base, vecs[i].step,
                       vecs[i].exp_hdr, vecs[i].exp_trl, 1'b0);
            wait_drain(500);
        end
        check("table_frames", frames_seen, frames_exp);

        // MISO word offered before any ID must wait.
        expect_frame(32'hA55A0009, 1'b0, 1, 32'hAB, 32'h0, 32'h5AA50001);
        bus.miso_tvalid = 1'b1;
        bus.miso_tdata  = 32'hAB;
        bus.miso_tlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("noid_miso_tready", bus.miso_tready, 1'b0);
        end
        check("noid_resp_tvalid", bus.resp_tvalid, 1'b0);
        @(posedge aclk);
        #1;
        push_id(1'b0, 8'h09);
        send_miso(32'hAB, 1'b1);
        wait_drain(500);

        // Fill the ID queue behind a stalled header, then push while the FSM pops.
        rdy_mode = 2;
        repeat (2) @(posedge aclk);
        #1;
        for (int i = 0; i < 5; i++) begin
            expect_frame({16'hA55A, 8'h00, 8'(8'h40 + i)}, 1'b1, 0, 32'h0, 32'h0, 32'h5AA50000);
            push_id(1'b1, 8'(8'h40 + i));
        end
        @(negedge aclk);
        check("id_full_tready", bus.id_tready, 1'b0);
        @(posedge aclk);
        #1;
        expect_frame(32'hA55A0045, 1'b1, 0, 32'h0, 32'h0, 32'h5AA50000);
        bus.id_tvalid = 1'b1;
        bus.id_tdata  = {1'b1, 8'h45};
        rdy_mode      = 0;
        begin
            int t = 0;
            forever begin
                @(negedge aclk);
                if (bus.frame_done) break;
                t++;
                if (t > 500) begin
                    timeout("first_frame_done");
                    break;
                end
            end
        end
        check("push_pop_full_tready", bus.id_tready, 1'b1);
        @(posedge aclk);
        #1;
        bus.id_tvalid = 1'b0;
        wait_drain(1000);

        // Reset in the middle of a frame with a second ID queued.
        exp_q.push_back('{32'hA55A0021, 1'b0});
        exp_q.push_back('{32'h0000AA01, 1'b0});
        exp_q.push_back('{32'h0000AA02, 1'b0});
        push_id(1'b0, 8'h21);
        send_miso(32'h0000AA01, 1'b0);
        send_miso(32'h0000AA02, 1'b0);
        wait_drain(500);
        push_id(1'b0, 8'h22);
        rdy_mode = 2;
        repeat (2) @(posedge aclk);
        #1;
        send_miso(32'h0000AA03, 1'b0);
        check("pre_reset_resp_tvalid", bus.resp_tvalid, 1'b1);
        #2;
        areset = 1'b1;
        #1;
        check("mid_rst_resp_tvalid", bus.resp_tvalid, 1'b0);
        check("mid_rst_resp_tdata", bus.resp_tdata, 32'h0);
        check("mid_rst_resp_tlast", bus.resp_tlast, 1'b0);
        check("mid_rst_miso_tready", bus.miso_tready, 1'b0);
        check("mid_rst_frame_done", bus.frame_done, 1'b0);
        exp_q.delete();
        rdy_mode = 0;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        check("flushed_no_header", bus.resp_tvalid, 1'b0);
        send_frame(8'h31, 1'b0, 2, 32'hC0, 32'h1, 32'hA55A0031, 32'h5AA50002, 1'b0);
        wait_drain(500);

        // 100 random frames under 30% downstream stall.
        rdy_mode = 1;
        for (int f = 0; f < 100; f++) begin
            logic [7:0] id;
            logic       empty;
            int         n;
            id    = 8'($urandom);
            empty = ($urandom_range(0, 7) == 0);
            n     = empty ? 0 : int'($urandom_range(1, 6));
            send_frame(id, empty, n, $urandom, $urandom, {16'hA55A, 8'h00, id},
                       {16'h5AA5, 16'(n)}, 1'b1);
        end
        wait_drain(5000);

        check("total_frames", frames_seen, frames_exp);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
